// File: rtl/led_pattern_engine.sv
// Parametrised LED animation engine: two-stage prescaler, eight selectable
// patterns with direction control, and step/wrap pulses on each advance.
module led_pattern_engine #(
  parameter int N_LEDS   = 8,
  parameter int DIV_BASE = 1000000,
  parameter int SPEED_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [2:0]         pat_sel,
  input  logic [SPEED_W-1:0] speed,
  input  logic               pause,
  input  logic               dir,
  output logic [N_LEDS-1:0]  led_out,
  output logic               step,
  output logic               wrap
);

  localparam int BASE_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(DIV_BASE - 1);

  typedef enum logic [2:0] {
    PAT_WALK1, PAT_WALK0, PAT_BOUNCE, PAT_BIN,
    PAT_JOHNSON, PAT_ALT, PAT_GRAY, PAT_BLINK
  } pat_e;

  logic [BASE_W-1:0]  base_cnt;
  logic [SPEED_W-1:0] spd_cnt;
  logic [N_LEDS-1:0]  state;
  logic               bounce_down;
  pat_e               shadow;

  logic               base_tick;
  logic               advance;
  logic [N_LEDS-1:0]  adv_state;
  logic               adv_down;
  pat_e               new_pat;

  function automatic logic [N_LEDS-1:0] init_of(input pat_e p);
    logic [N_LEDS-1:0] alt;
    for (int i = 0; i < N_LEDS; i++) alt[i] = ((i % 2) == 0);
    case (p)
      PAT_WALK1, PAT_BOUNCE: return N_LEDS'(1);
      PAT_WALK0:             return ~N_LEDS'(1);
      PAT_ALT:               return alt;
      default:               return '0;
    endcase
  endfunction

  // The Gray pattern keeps a plain binary count internally; only the view is encoded.
  function automatic logic [N_LEDS-1:0] show(input logic [N_LEDS-1:0] s, input pat_e p);
    return (p == PAT_GRAY) ? (s ^ (s >> 1)) : s;
  endfunction

  assign new_pat = pat_e'(pat_sel);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    base_tick = (base_cnt == BASE_LAST);
    // >= also catches a speed lowered below the running count.
    advance   = base_tick && (spd_cnt >= speed);
    adv_state = state;
    adv_down  = bounce_down;
    case (shadow)
      PAT_WALK1, PAT_WALK0:
        adv_state = dir ? {state[0], state[N_LEDS-1:1]} : {state[N_LEDS-2:0], state[N_LEDS-1]};
      PAT_BOUNCE:
        if (!bounce_down) begin
          if (state[N_LEDS-1]) begin
            adv_state = state >> 1;
            adv_down  = 1'b1;
          end else begin
            adv_state = state << 1;
          end
        end else begin
          if (state[0]) begin
            adv_state = state << 1;
            adv_down  = 1'b0;
          end else begin
            adv_state = state >> 1;
          end
        end
      PAT_BIN, PAT_GRAY:
        adv_state = dir ? state - N_LEDS'(1) : state + N_LEDS'(1);
      PAT_JOHNSON:
        adv_state = dir ? {~state[0], state[N_LEDS-1:1]} : {state[N_LEDS-2:0], ~state[N_LEDS-1]};
      default:
        adv_state = ~state;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every register
  // samples the pre-edge values and block ordering cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_cnt    <= '0;
      spd_cnt     <= '0;
      state       <= N_LEDS'(1);
      bounce_down <= 1'b0;
      shadow      <= PAT_WALK1;
      led_out     <= '0;
      step        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
      if (!ena || (new_pat != shadow)) begin
        // Disable and pattern change share the restart path; only the display differs.
        base_cnt    <= '0;
        spd_cnt     <= '0;
        state       <= init_of(new_pat);
        bounce_down <= 1'b0;
        shadow      <= new_pat;
        led_out     <= ena ? show(init_of(new_pat), new_pat) : '0;
      end else if (!pause) begin
        if (base_tick) begin
          base_cnt <= '0;
          spd_cnt  <= advance ? '0 : spd_cnt + SPEED_W'(1);
        end else begin
          base_cnt <= base_cnt + BASE_W'(1);
        end
        if (advance) begin
          state       <= adv_state;
          bounce_down <= adv_down;
          led_out     <= show(adv_state, shadow);
          step        <= 1'b1;
          wrap        <= (adv_state == init_of(shadow));
        end else begin
          led_out     <= show(state, shadow);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: stimulus queues expected step
// outputs, a negedge monitor pops and compares them on every step pulse.
module tb_led_pattern_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] pat_sel;
  logic [2:0] speed;
  logic       pause;
  logic       dir;
  logic [7:0] led_out;
  logic       step;
  logic       wrap;

  led_pattern_engine #(.N_LEDS(8), .DIV_BASE(4), .SPEED_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .pat_sel(pat_sel), .speed(speed),
    .pause(pause), .dir(dir), .led_out(led_out), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] led;
    logic       wrap;
    int         gap;   // cycles since previous step; 0 = not checked
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_step = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] led, input logic w, input int gap);
    exp_t e;
    e.led = led; e.wrap = w; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push_seq(input logic [7:0] seq[], input int wrap_idx);
    foreach (seq[i]) push(seq[i], (i == wrap_idx), (i == 0) ? 0 : 4);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
    check("drain_queue", q.size(), 0);
    q.delete();
  endtask

  task automatic set_pat(input logic [2:0] p, input logic d, input logic [7:0] init_exp);
    @(negedge clk);
    pat_sel = p;
    dir     = d;
    @(negedge clk);
    check("pat_init", led_out, init_exp);
    check("pat_no_step", {step, wrap}, 2'b00);
  endtask

  // Monitor: compares every step pulse against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && step) begin
      if (q.size() == 0) begin
        check("unexpected_step", led_out, 8'hxx);
      end else begin
        e = q.pop_front();
        check("step_led", led_out, e.led);
        check("step_wrap", wrap, e.wrap);
        if (e.gap != 0) check("step_gap", cyc - last_step, e.gap);
      end
      last_step = cyc;
    end else if (rst_n && wrap) begin
      check("wrap_without_step", wrap, 1'b0);
    end
  end

  initial begin
    logic [7:0] held;
    logic       bad;
    logic       seen;

    rst_n = 1'b0; ena = 1'b1; pat_sel = 3'd0; speed = 3'd0; pause = 1'b0; dir = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", led_out, 8'h00);
    check("rst_step", step, 1'b0);
    check("rst_wrap", wrap, 1'b0);

    // Walking one, speed 0: step every 4 cycles, wrap on 80 -> 01.
    push_seq('{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02}, 7);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_init", led_out, 8'h01);
    drain(100);

    // Speed 2: 12-cycle spacing, then a 20-cycle pause stretches one gap to 32.
    speed = 3'd2;
    push(8'h04, 1'b0, 12);
    push(8'h08, 1'b0, 12);
    drain(100);
    pause = 1'b1;
    held  = led_out;
    bad   = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (step || wrap || led_out !== held) bad = 1'b1;
    end
    check("pause_frozen", bad, 1'b0);
    push(8'h10, 1'b0, 32);
    push(8'h20, 1'b0, 12);
    pause = 1'b0;
    drain(100);

    // Bounce: 14 steps back to 01 with wrap.
    speed = 3'd0;
    push_seq('{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, 13);
    set_pat(3'd2, 1'b0, 8'h01);
    drain(200);

    // Johnson fill, dir=1: 16 steps back to 00 with wrap.
    push_seq('{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
               8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00}, 15);
    set_pat(3'd4, 1'b1, 8'h00);
    drain(200);

    // Binary counter down from 0.
    push_seq('{8'hFF, 8'hFE}, -1);
    set_pat(3'd3, 1'b1, 8'h00);
    drain(50);

    // Gray counter up.
    push_seq('{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04}, -1);
    set_pat(3'd6, 1'b0, 8'h00);
    drain(100);

    // Pattern change colliding with a pending advance: change wins, counters restart.
    push(8'h02, 1'b0, 0);
    set_pat(3'd0, 1'b0, 8'h01);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = step;
    end
    check("sync_step", seen, 1'b1);
    repeat (3) @(negedge clk);
    pat_sel = 3'd5;
    @(negedge clk);
    check("chg_led", led_out, 8'h55);
    check("chg_no_pulse", {step, wrap}, 2'b00);
    push(8'hAA, 1'b0, 8);
    push(8'h55, 1'b1, 4);
    drain(50);

    // Enable drop blanks on the next edge; re-enable restarts from init.
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena_blank", led_out, 8'h00);
    check("ena_no_step", step, 1'b0);
    push(8'hAA, 1'b0, 0);
    ena = 1'b1;
    @(negedge clk);
    check("ena_restart", led_out, 8'h55);
    drain(50);

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", led_out, 8'h00);
    repeat (2) @(negedge clk);
    push(8'hAA, 1'b0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart", led_out, 8'h55);
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
Name: led_pattern_engine

Overview:
Parametrised successor to the team's fixed 8-LED pattern generator. Drives N_LEDS outputs with one of eight selectable animations. Adds direction control, a programmable multi-bit speed divider, step/wrap status pulses, and clean restart on pattern change. Sits between the top-level ui_in decode and uo_out, or drives a wider LED bank on uio.

Parameters:
N_LEDS, 8, number of LED outputs; legal range 2..32.
DIV_BASE, 1000000, base prescaler period in clk cycles; minimum 1.
SPEED_W, 3, width of the speed select input.

Ports:
clk      input   1          system clock
rst_n    input   1          reset, asynchronous assert, active-low
ena      input   1          run enable; low blanks the output and holds the engine at its initial state
pat_sel  input   3          pattern select
speed    input   SPEED_W    step period = (speed+1)*DIV_BASE clk cycles
pause    input   1          freezes prescalers and pattern state
dir      input   1          0 = up/left, 1 = down/right
led_out  output  N_LEDS     registered pattern
step     output  1          1-cycle pulse on each pattern advance
wrap     output  1          1-cycle pulse when an advance returns the pattern to its initial state

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. While rst_n is low: led_out=0, step=0, wrap=0, prescalers=0, bin counter=0, bounce direction=up, pat_sel shadow=0.
- Prescaler, two stages:
  - base_cnt counts 0..DIV_BASE-1 and emits base_tick at DIV_BASE-1.
  - spd_cnt counts base_ticks 0..speed; an advance occurs on the base_tick where spd_cnt==speed.
  - speed is sampled live. If spd_cnt>speed after a speed change, an advance occurs on the next base_tick and spd_cnt clears.
- Advance: the pattern register updates on the same edge, and step=1 on that cycle's registered output (same edge as the led_out change).
- pause=1: both counters and all pattern state hold. step and wrap stay 0. led_out keeps its value.
- ena=0: led_out=0, counters clear, pattern state is reloaded with the init value (not shown). On the first cycle with ena=1, led_out shows the init value.
- Pattern change: pat_sel is registered as a shadow. When pat_sel differs from the shadow (ena=1), on that edge:
  - the shadow updates, counters clear, the pattern loads its init value, bounce direction resets to up;
  - no step or wrap pulse.
  - pat_sel change takes priority over an advance in the same cycle.
- Patterns (bit0 = LSB). Each line gives init, then the advance rule for dir=0 / dir=1.
  - 0 walking one: init 0..01; rotate left / rotate right.
  - 1 walking zero: init 1..10; rotate left / rotate right.
  - 2 bounce: init 0..01; single 1 moves toward MSB, reverses at MSB, reverses again at bit0; dir ignored; period 2*N_LEDS-2.
  - 3 binary counter: init 0; +1 / -1 modulo 2^N_LEDS.
  - 4 Johnson fill: init 0; {led[N-2:0], ~led[N-1]} / {~led[0], led[N-1:1]}; period 2*N_LEDS.
  - 5 alternate: init 0101..01 (bit0=1); invert each advance.
  - 6 Gray counter: internal binary count ±1 per dir; led_out = cnt ^ (cnt>>1); init 0.
  - 7 blink: init 0; invert each advance.
- wrap=1 exactly when an advance produces the init value of the current pattern (under ena=1), coincident with step.
- dir may change mid-pattern: takes effect on the next advance, with no reload.
- Unused prescaler widths are sized by $clog2. No combinational path from inputs to outputs.

Test Plan:
- N_LEDS=8, DIV_BASE=4, speed=0, pat_sel=0, dir=0, ena=1 after reset: led_out 01,02,04,…,80,01, one step every 4 cycles; wrap pulses with the 80→01 transition.
- Same bench, speed=2: step spacing 12 cycles. pause high for 20 cycles mid-run: led_out frozen, no step pulses, counting resumes from the held spd_cnt/base_cnt.
- pat_sel=2 (bounce): sequence 01,02,…,80,40,…,02,01 with wrap on the return to 01 after 14 steps. pat_sel=4, dir=1: 00,80,C0,E0,…,FF,7F,…,01,00, wrap after 16 steps.
- pat_sel=3, dir=1 from init: 00→FF→FE. pat_sel=6, dir=0: 00,01,03,02,06,07,05,04.
- Switch pat_sel 0→5 in the same cycle as a pending advance: next led_out=55, no step/wrap pulse, next advance after a full 4 cycles gives AA.
- Drop ena mid-pattern: led_out=00 on the next edge. Assert rst_n low asynchronously between edges: led_out=00 immediately. After release with ena=1, pattern restarts from init.
